rf_wb_arbiter: RTL and testbench
================================

RF_WB_ARBITER -- requirements
Module: rf_wb_arbiter

Interface
REQ-001 The block SHALL have parameter DEPTH, default 2, meaning MDU result FIFO entries (power of two, 2..8).
REQ-002 The block SHALL have port clk  input  1  system clock; register file writes on negedge, arbiter state updates on posedge.
REQ-003 The block SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-004 The block SHALL have port wb_en  input  1  pipeline WB stage write request.
REQ-005 The block SHALL have port wb_addr  input  5  pipeline WB destination register.
REQ-006 The block SHALL have port wb_data  input  32  pipeline WB write data.
REQ-007 The block SHALL have port mdu_valid  input  1  multiply/divide result valid.
REQ-008 The block SHALL have port mdu_ready  output  1  FIFO can accept; mdu_ready = !full.
REQ-009 The block SHALL have port mdu_addr  input  5  MDU destination register.
REQ-010 The block SHALL have port mdu_data  input  32  MDU result data.
REQ-011 The block SHALL have port rf_we  output  1  to RF RFWr.
REQ-012 The block SHALL have port rf_addr  output  5  to RF A3.
REQ-013 The block SHALL have port rf_wd  output  32  to RF WD.
REQ-014 The block SHALL have ports q_a1, q_a2  input  5 each  decode-stage read addresses (RF A1/A2).
REQ-015 The block SHALL have ports pend1, pend2  output  1 each  a live FIFO entry targets q_a1/q_a2.
REQ-016 The block SHALL have port blk_cnt  output  16  saturating count of cycles in which a live head was blocked by WB.

Function
REQ-017 Priority: a WB write (wb_en=1, wb_addr!=0) SHALL own the RF port that cycle: rf_we=1, rf_addr=wb_addr, rf_wd=wb_data, all combinational.
REQ-018 When no WB write is made, a non-empty FIFO SHALL pop its head: rf_we = head live bit, rf_addr/rf_wd = head fields.
REQ-019 A killed head SHALL be popped with rf_we=0.
REQ-020 With no WB write and an empty FIFO, rf_we SHALL be 0, and rf_addr/rf_wd SHALL be 0.
REQ-021 wb_en with wb_addr=0 SHALL be treated as no write; the FIFO may drain that cycle.
REQ-022 An MDU handshake (mdu_valid & mdu_ready) SHALL enqueue {addr, data, live=(mdu_addr!=0)} at posedge.
REQ-023 Minimum MDU-to-RF latency SHALL be 1 cycle: an entry accepted at edge N is eligible to pop in cycle N+1.
REQ-024 A simultaneous push and pop SHALL be allowed, and occupancy SHALL be unchanged by them.
REQ-025 A push when full SHALL never occur, since ready is low.
REQ-026 Full SHALL be determined by occupancy before the pop, so ready does not depend combinationally on wb_en.
REQ-027 WAW kill: a WB write at posedge SHALL clear the live bit of every FIFO entry already stored with an equal addr.
REQ-028 An entry being enqueued in the same cycle SHALL NOT be killed; the MDU result is defined as younger.
REQ-029 pend1 SHALL be 1 iff q_a1!=0 and any occupied entry is live with addr==q_a1; pend2 SHALL be defined likewise. Both are combinational.
REQ-030 blk_cnt SHALL increment when wb_en=1, wb_addr!=0 and the head is occupied and live.
REQ-031 blk_cnt SHALL saturate at 0xFFFF.
REQ-032 Pointers SHALL wrap modulo DEPTH.
REQ-033 Occupancy SHALL be a log2(DEPTH)+1 bit counter.

Reset
REQ-034 rst low SHALL asynchronously clear the pointers, the occupancy count, all live bits and blk_cnt.
REQ-035 After reset, mdu_ready=1, rf_we=0 (unless wb_en is asserted), and pend1=pend2=0.
REQ-036 Reset mid-operation SHALL discard queued results with no RF write.
REQ-037 Entry data/addr fields need no reset.

Structure
REQ-038 The shared package SHALL hold the REG_W=5 and DATA_W=32 constants and the FIFO entry typedef {addr, data, live}.
REQ-039 FIFO storage with pointers SHALL be one sub-module, wb_fifo; kill/pend compare logic SHALL stay in the top.

Verification
REQ-040 After reset, mdu_valid=1 with r5=0x0000_00AA and wb_en=0 -> the next cycle gives rf_we=1, rf_addr=5, rf_wd=0xAA, and pend(q_a1=5) is high only during the queued cycle.
REQ-041 DEPTH=2, wb_en=1 (r1) held 4 cycles while MDU pushes r2, r3, r4 -> ready drops after 2 pushes, blk_cnt=4, and r2 then r3 drain in order once wb_en=0.
REQ-042 MDU pushes r7=0x11; the next cycle WB writes r7=0x22 -> the entry is killed, no later RF write to r7 occurs, and pend for r7 goes low.
REQ-043 MDU push to r0 -> the entry is popped with rf_we=0, and pend(q_a1=0)=0.
REQ-044 WB and MDU both target r9 in the same cycle -> WB=0x1 is written first, then MDU=0x2 the next cycle.
REQ-045 Assert rst with 2 entries queued -> no RF write follows, and mdu_ready=1 immediately.

Source files
------------

// File: rtl/rf_wb_arbiter_pkg.sv
// rf_wb_arbiter_pkg: shared widths and the MDU result FIFO entry type
package rf_wb_arbiter_pkg;
  localparam int REG_W = 5;
  localparam int DATA_W = 32;
  typedef struct packed {
    logic [REG_W-1:0]  addr;
    logic [DATA_W-1:0] data;
    logic              live;
  } wb_entry_t;
endpackage

// File: rtl/wb_fifo.sv
// wb_fifo: MDU result FIFO with per-entry live bits that the owner can clear by slot
module wb_fifo
  import rf_wb_arbiter_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic                         push_i,
  input  wb_entry_t                    entry_i,
  input  logic                         pop_i,
  input  logic [DEPTH-1:0]             kill_i,
  output wb_entry_t                    head_o,
  output logic [DEPTH-1:0][REG_W-1:0]  addr_o,
  output logic [DEPTH-1:0]             live_o,
  output logic [DEPTH-1:0]             occ_o,
  output logic                         full_o,
  output logic                         empty_o
);
  localparam int AW = $clog2(DEPTH);
  logic [AW-1:0] wr_q, rd_q;
  logic [AW:0] cnt_q;
  logic [DEPTH-1:0][REG_W-1:0] addr_q;
  logic [DEPTH-1:0][DATA_W-1:0] data_q;
  logic [DEPTH-1:0] live_q, live_d;
  // the slot being written takes the new live bit, so a same-cycle kill never hits it
  always_comb begin
    live_d = live_q & ~kill_i;
    if (push_i) live_d[wr_q] = entry_i.live;
  end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_q <= '0;
      rd_q <= '0;
      cnt_q <= '0;
      live_q <= '0;
    end else begin
      wr_q <= push_i ? wr_q + AW'(1) : wr_q;
      rd_q <= pop_i ? rd_q + AW'(1) : rd_q;
      cnt_q <= cnt_q + {{AW{1'b0}}, push_i & ~pop_i} - {{AW{1'b0}}, pop_i & ~push_i};
      live_q <= live_d;
    end
  end
  always_ff @(posedge clk_i) begin
    if (push_i) begin
      addr_q[wr_q] <= entry_i.addr;
      data_q[wr_q] <= entry_i.data;
    end
  end
  for (genvar g = 0; g < DEPTH; g++) begin : g_occ
    assign occ_o[g] = {1'b0, AW'(g) - rd_q} < cnt_q;
  end
  assign addr_o = addr_q;
  assign live_o = live_q;
  assign head_o = '{addr: addr_q[rd_q], data: data_q[rd_q], live: live_q[rd_q]};
  assign full_o = cnt_q == (AW+1)'(DEPTH);
  assign empty_o = cnt_q == '0;
endmodule

// File: rtl/rf_wb_arbiter.sv
// rf_wb_arbiter: shares the RF write port between the WB stage and queued MDU results,
// killing stale MDU results (WAW) and flagging pending destinations to decode
module rf_wb_arbiter
  import rf_wb_arbiter_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wb_en,
  input  logic [REG_W-1:0]  wb_addr,
  input  logic [DATA_W-1:0] wb_data,
  input  logic              mdu_valid,
  output logic              mdu_ready,
  input  logic [REG_W-1:0]  mdu_addr,
  input  logic [DATA_W-1:0] mdu_data,
  output logic              rf_we,
  output logic [REG_W-1:0]  rf_addr,
  output logic [DATA_W-1:0] rf_wd,
  input  logic [REG_W-1:0]  q_a1,
  input  logic [REG_W-1:0]  q_a2,
  output logic              pend1,
  output logic              pend2,
  output logic [15:0]       blk_cnt
);
  wb_entry_t head;
  logic [DEPTH-1:0][REG_W-1:0] slot_addr;
  logic [DEPTH-1:0] slot_live, occ, kill, hit1, hit2;
  logic full, empty, wb_wr, push, pop;
  logic [15:0] blk_q, blk_d;
  assign wb_wr = wb_en & (wb_addr != '0);
  assign push = mdu_valid & ~full;
  assign pop = ~wb_wr & ~empty;
  assign mdu_ready = ~full;
  wb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk_i(clk),
    .rst_ni(rst),
    .push_i(push),
    .entry_i('{addr: mdu_addr, data: mdu_data, live: mdu_addr != '0}),
    .pop_i(pop),
    .kill_i(kill),
    .head_o(head),
    .addr_o(slot_addr),
    .live_o(slot_live),
    .occ_o(occ),
    .full_o(full),
    .empty_o(empty)
  );
  for (genvar g = 0; g < DEPTH; g++) begin : g_cmp
    assign kill[g] = wb_wr & (slot_addr[g] == wb_addr);
    assign hit1[g] = occ[g] & slot_live[g] & (slot_addr[g] == q_a1);
    assign hit2[g] = occ[g] & slot_live[g] & (slot_addr[g] == q_a2);
  end
  assign pend1 = (q_a1 != '0) & |hit1;
  assign pend2 = (q_a2 != '0) & |hit2;
  always_comb begin
    rf_we = wb_wr | (~empty & head.live);
    rf_addr = wb_wr ? wb_addr : empty ? '0 : head.addr;
    rf_wd = wb_wr ? wb_data : empty ? '0 : head.data;
    blk_d = (wb_wr & ~empty & head.live & ~&blk_q) ? blk_q + 16'd1 : blk_q;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) blk_q <= '0;
    else blk_q <= blk_d;
  end
  assign blk_cnt = blk_q;
endmodule

// File: tb/tb_rf_wb_arbiter.sv
// tb_rf_wb_arbiter: directed scenarios plus random traffic against a queue-based reference
module tb_rf_wb_arbiter;
  import rf_wb_arbiter_pkg::*;
  localparam int DEPTH = 2;
  logic clk = 0, rst = 0;
  logic wb_en = 0, mdu_valid = 0;
  logic [4:0] wb_addr = '0, mdu_addr = '0, q_a1 = '0, q_a2 = '0;
  logic [31:0] wb_data = '0, mdu_data = '0;
  logic mdu_ready, rf_we, pend1, pend2;
  logic [4:0] rf_addr;
  logic [31:0] rf_wd;
  logic [15:0] blk_cnt;
  int n_vec = 0, n_err = 0, mblk = 0;
  wb_entry_t mq[$];
  always #5 clk = ~clk;
  rf_wb_arbiter #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
    .mdu_valid(mdu_valid), .mdu_ready(mdu_ready), .mdu_addr(mdu_addr), .mdu_data(mdu_data),
    .rf_we(rf_we), .rf_addr(rf_addr), .rf_wd(rf_wd), .q_a1(q_a1), .q_a2(q_a2),
    .pend1(pend1), .pend2(pend2), .blk_cnt(blk_cnt)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask
  // one cycle: drive after negedge, compare before posedge, advance the reference
  task automatic cyc(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                     input logic mv, input logic [4:0] ma, input logic [31:0] md,
                     input logic [4:0] a1, input logic [4:0] a2);
    logic wbw, rdy, e_we, p1, p2;
    logic [4:0] e_addr;
    logic [31:0] e_wd;
    @(negedge clk);
    wb_en = we; wb_addr = wa; wb_data = wd;
    mdu_valid = mv; mdu_addr = ma; mdu_data = md; q_a1 = a1; q_a2 = a2;
    #1;
    wbw = we && wa != 0;
    rdy = mq.size() < DEPTH;
    e_we = 0; e_addr = 0; e_wd = 0;
    if (wbw) begin e_we = 1; e_addr = wa; e_wd = wd; end
    else if (mq.size() > 0) begin e_we = mq[0].live; e_addr = mq[0].addr; e_wd = mq[0].data; end
    p1 = 0; p2 = 0;
    foreach (mq[i]) begin
      if (mq[i].live && mq[i].addr == a1) p1 = 1;
      if (mq[i].live && mq[i].addr == a2) p2 = 1;
    end
    p1 &= a1 != 0; p2 &= a2 != 0;
    check("ready", 32'(mdu_ready), 32'(rdy));
    check("rf_we", 32'(rf_we), 32'(e_we));
    check("rf_addr", 32'(rf_addr), 32'(e_addr));
    check("rf_wd", rf_wd, e_wd);
    check("pend1", 32'(pend1), 32'(p1));
    check("pend2", 32'(pend2), 32'(p2));
    check("blk_cnt", 32'(blk_cnt), 32'(mblk));
    if (wbw && mq.size() > 0 && mq[0].live && mblk < 16'hFFFF) mblk++;
    if (wbw) foreach (mq[i]) if (mq[i].addr == wa) mq[i].live = 0;
    if (!wbw && mq.size() > 0) void'(mq.pop_front());
    if (mv && rdy) mq.push_back('{addr: ma, data: md, live: ma != 0});
  endtask
  initial begin
    repeat (2) @(negedge clk);
    check("rst_ready", 32'(mdu_ready), 1);
    check("rst_we", 32'(rf_we), 0);
    check("rst_pend1", 32'(pend1), 0);
    check("rst_blk", 32'(blk_cnt), 0);
    rst = 1;
    // single MDU result reaches the RF one cycle later
    cyc(0, 0, 0, 1, 5, 32'hAA, 5, 0);
    cyc(0, 0, 0, 0, 0, 0, 5, 0);
    cyc(0, 0, 0, 0, 0, 0, 5, 0);
    // WB holds the port for 4 cycles while the FIFO fills
    cyc(0, 0, 0, 1, 2, 32'h200, 0, 0);
    cyc(1, 1, 32'h100, 1, 3, 32'h300, 2, 3);
    cyc(1, 1, 32'h101, 1, 4, 32'h400, 2, 3);
    cyc(1, 1, 32'h102, 1, 4, 32'h400, 2, 3);
    cyc(1, 1, 32'h103, 1, 4, 32'h400, 2, 3);
    cyc(0, 0, 0, 0, 0, 0, 2, 3);
    check("blk_after_hold", 32'(blk_cnt), 4);
    repeat (3) cyc(0, 0, 0, 0, 0, 0, 2, 3);
    // WAW kill of a queued result
    cyc(0, 0, 0, 1, 7, 32'h11, 7, 0);
    cyc(1, 7, 32'h22, 0, 0, 0, 7, 0);
    cyc(0, 0, 0, 0, 0, 0, 7, 0);
    check("kill_pend", 32'(pend1), 0);
    // MDU result to r0 is dropped silently
    cyc(0, 0, 0, 1, 0, 32'h33, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0, 0);
    // same-cycle WB and MDU to r9: MDU is younger and survives
    cyc(1, 9, 32'h1, 1, 9, 32'h2, 9, 0);
    cyc(0, 0, 0, 0, 0, 0, 9, 0);
    check("r9_second", rf_wd, 32'h2);
    cyc(0, 0, 0, 0, 0, 0, 0, 0);
    // reset with two results queued
    cyc(1, 1, 32'h5, 1, 10, 32'hA0, 10, 11);
    cyc(1, 1, 32'h6, 1, 11, 32'hB0, 10, 11);
    @(negedge clk);
    wb_en = 0; mdu_valid = 0;
    #2 rst = 0;
    #1;
    check("mid_rst_ready", 32'(mdu_ready), 1);
    check("mid_rst_we", 32'(rf_we), 0);
    check("mid_rst_pend", 32'(pend1 | pend2), 0);
    check("mid_rst_blk", 32'(blk_cnt), 0);
    mq.delete();
    mblk = 0;
    @(negedge clk) rst = 1;
    repeat (3) cyc(0, 0, 0, 0, 0, 0, 10, 11);
    for (int i = 0; i < 400; i++)
      cyc(1'($urandom_range(0, 2) == 0), 5'($urandom_range(0, 3)), $urandom,
          1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)), $urandom,
          5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)));
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
